// File: rtl/issue_read_arbiter_pkg.sv
// Shared types, widths and helpers for the issue read arbiter.
package issue_read_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PREG_W = 7;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_BR  = 2'd1,
    FU_LSU = 2'd2
  } fu_sel_e;

  typedef struct packed {
    logic [PREG_W-1:0] pr1;
    logic [PREG_W-1:0] pr2;
    logic [PREG_W-1:0] prd;
    logic [4:0]        opcode;
  } rs_data;

  typedef struct packed {
    rs_data            pkt;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } issue_slot_t;

  function automatic fu_sel_e f_next_ptr(input fu_sel_e w);
    case (w)
      FU_ALU:  f_next_ptr = FU_BR;
      FU_BR:   f_next_ptr = FU_LSU;
      default: f_next_ptr = FU_ALU;
    endcase
  endfunction

  // Scans high slot to low so the lowest matching CDB slot is the final assignment.
  function automatic logic [DATA_W-1:0] f_operand(
    input logic [PREG_W-1:0]           s,
    input logic [DATA_W-1:0]           prf,
    input logic [2:0]                  v,
    input logic [2:0][PREG_W-1:0]      tag,
    input logic [2:0][DATA_W-1:0]      data
  );
    f_operand = prf;
    for (int unsigned k = 0; k < 3; k++) begin
      if (v[2-k] && (tag[2-k] == s)) f_operand = data[2-k];
    end
    if (s == '0) f_operand = '0;
  endfunction

endpackage

// File: rtl/issue_read_arbiter_if.sv
// RS request, PRF read, CDB and FU slot signals of the issue read arbiter.
interface issue_read_arbiter_if import issue_read_arbiter_pkg::*; ();
  logic                    alu_req_valid, b_req_valid, lsu_req_valid;
  rs_data                  alu_req_data, b_req_data, lsu_req_data;
  logic                    alu_req_ready, b_req_ready, lsu_req_ready;
  logic [PREG_W-1:0]       prf_raddr1, prf_raddr2;
  logic [DATA_W-1:0]       prf_rdata1, prf_rdata2;
  logic [2:0]              cdb_valid;
  logic [2:0][PREG_W-1:0]  cdb_tag;
  logic [2:0][DATA_W-1:0]  cdb_data;
  logic                    alu_fu_valid, b_fu_valid, lsu_fu_valid;
  rs_data                  alu_fu_data, b_fu_data, lsu_fu_data;
  logic [DATA_W-1:0]       alu_fu_op1, b_fu_op1, lsu_fu_op1;
  logic [DATA_W-1:0]       alu_fu_op2, b_fu_op2, lsu_fu_op2;
  logic                    alu_fu_ready, b_fu_ready, lsu_fu_ready;

  modport master (
    input  alu_req_valid, b_req_valid, lsu_req_valid,
    input  alu_req_data, b_req_data, lsu_req_data,
    output alu_req_ready, b_req_ready, lsu_req_ready,
    output prf_raddr1, prf_raddr2,
    input  prf_rdata1, prf_rdata2,
    input  cdb_valid, cdb_tag, cdb_data,
    output alu_fu_valid, b_fu_valid, lsu_fu_valid,
    output alu_fu_data, b_fu_data, lsu_fu_data,
    output alu_fu_op1, b_fu_op1, lsu_fu_op1,
    output alu_fu_op2, b_fu_op2, lsu_fu_op2,
    input  alu_fu_ready, b_fu_ready, lsu_fu_ready
  );

  modport slave (
    output alu_req_valid, b_req_valid, lsu_req_valid,
    output alu_req_data, b_req_data, lsu_req_data,
    input  alu_req_ready, b_req_ready, lsu_req_ready,
    input  prf_raddr1, prf_raddr2,
    output prf_rdata1, prf_rdata2,
    output cdb_valid, cdb_tag, cdb_data,
    input  alu_fu_valid, b_fu_valid, lsu_fu_valid,
    input  alu_fu_data, b_fu_data, lsu_fu_data,
    input  alu_fu_op1, b_fu_op1, lsu_fu_op1,
    input  alu_fu_op2, b_fu_op2, lsu_fu_op2,
    output alu_fu_ready, b_fu_ready, lsu_fu_ready
  );
endinterface

// File: rtl/issue_read_arbiter_rr_arbiter3.sv
// Three-way round-robin arbiter: one-hot grant and winner index, highest priority at i_ptr.
module rr_arbiter3 import issue_read_arbiter_pkg::*; (
  input  logic [2:0] i_eligible,
  input  fu_sel_e    i_ptr,
  output logic [2:0] o_grant,
  output fu_sel_e    o_winner
);
  logic [1:0] w_idx;
  logic       w_found;

  always_comb begin
    o_grant  = '0;
    o_winner = FU_ALU;
    w_idx    = '0;
    w_found  = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      w_idx = 2'((32'(i_ptr) + k) % 3);
      if (!w_found && i_eligible[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_winner       = fu_sel_e'(w_idx);
        w_found        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/issue_read_arbiter.sv
// Grants one RS issue per cycle, reads both operands with CDB bypass and registers them per FU slot.
module issue_read_arbiter import issue_read_arbiter_pkg::*; #(
  parameter int unsigned RR_INIT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mispredict,
  issue_read_arbiter_if.master bus
);
  localparam fu_sel_e PTR_INIT = fu_sel_e'(2'(RR_INIT));

  logic [2:0]        w_req_valid, w_fu_ready, w_accept, w_eligible, w_grant;
  rs_data            w_req_data [3];
  fu_sel_e           w_winner;
  rs_data            w_pkt;
  logic [DATA_W-1:0] w_op1, w_op2;

  fu_sel_e           r_rr_ptr;
  issue_slot_t       r_slot [3];
  logic [2:0]        r_fu_valid;

  assign w_req_valid   = {bus.lsu_req_valid, bus.b_req_valid, bus.alu_req_valid};
  assign w_fu_ready    = {bus.lsu_fu_ready, bus.b_fu_ready, bus.alu_fu_ready};
  assign w_req_data[0] = bus.alu_req_data;
  assign w_req_data[1] = bus.b_req_data;
  assign w_req_data[2] = bus.lsu_req_data;

  // Reset is folded in so req_ready stays low while reset is asserted.
  assign w_accept   = ~r_fu_valid | w_fu_ready;
  assign w_eligible = w_req_valid & w_accept & {3{~mispredict & ~reset}};

  rr_arbiter3 u_arb (
    .i_eligible (w_eligible),
    .i_ptr      (r_rr_ptr),
    .o_grant    (w_grant),
    .o_winner   (w_winner)
  );

  always_comb begin
    w_pkt          = w_req_data[w_winner];
    bus.prf_raddr1 = '0;
    bus.prf_raddr2 = '0;
    if (|w_grant) begin
      bus.prf_raddr1 = w_pkt.pr1;
      bus.prf_raddr2 = w_pkt.pr2;
    end
    w_op1 = f_operand(w_pkt.pr1, bus.prf_rdata1, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    w_op2 = f_operand(w_pkt.pr2, bus.prf_rdata2, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fu_valid <= '0;
      r_rr_ptr   <= PTR_INIT;
      for (int unsigned i = 0; i < 3; i++) r_slot[i] <= '0;
    end else if (mispredict) begin
      r_fu_valid <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (w_grant[i]) begin
          r_slot[i]     <= '{pkt: w_pkt, op1: w_op1, op2: w_op2};
          r_fu_valid[i] <= 1'b1;
        end else if (r_fu_valid[i] && w_fu_ready[i]) begin
          r_fu_valid[i] <= 1'b0;
        end
      end
      if (|w_grant) r_rr_ptr <= f_next_ptr(w_winner);
    end
  end

  assign bus.alu_req_ready = w_grant[0];
  assign bus.b_req_ready   = w_grant[1];
  assign bus.lsu_req_ready = w_grant[2];

  assign bus.alu_fu_valid = r_fu_valid[0];
  assign bus.b_fu_valid   = r_fu_valid[1];
  assign bus.lsu_fu_valid = r_fu_valid[2];
  assign bus.alu_fu_data  = r_slot[0].pkt;
  assign bus.b_fu_data    = r_slot[1].pkt;
  assign bus.lsu_fu_data  = r_slot[2].pkt;
  assign bus.alu_fu_op1   = r_slot[0].op1;
  assign bus.b_fu_op1     = r_slot[1].op1;
  assign bus.lsu_fu_op1   = r_slot[2].op1;
  assign bus.alu_fu_op2   = r_slot[0].op2;
  assign bus.b_fu_op2     = r_slot[1].op2;
  assign bus.lsu_fu_op2   = r_slot[2].op2;
endmodule

// File: tb/tb_issue_read_arbiter.sv
// Directed bench for issue_read_arbiter with hand-computed grant, operand and slot expectations.
module tb_issue_read_arbiter;
  import issue_read_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset, mispredict;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  issue_read_arbiter_if bus ();

  issue_read_arbiter #(.RR_INIT(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .mispredict (mispredict),
    .bus        (bus.master)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic rs_data mk(input int unsigned p1, input int unsigned p2, input int unsigned pd);
    rs_data r;
    r.pr1    = PREG_W'(p1);
    r.pr2    = PREG_W'(p2);
    r.prd    = PREG_W'(pd);
    r.opcode = 5'h3;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] v);
    bus.alu_req_valid = v[0];
    bus.b_req_valid   = v[1];
    bus.lsu_req_valid = v[2];
  endtask

  task automatic set_ready(input logic [2:0] r);
    bus.alu_fu_ready = r[0];
    bus.b_fu_ready   = r[1];
    bus.lsu_fu_ready = r[2];
  endtask

  function automatic logic [2:0] grant_v();
    return {bus.lsu_req_ready, bus.b_req_ready, bus.alu_req_ready};
  endfunction

  function automatic logic [2:0] valid_v();
    return {bus.lsu_fu_valid, bus.b_fu_valid, bus.alu_fu_valid};
  endfunction

  initial begin
    logic [1:0] seq [6];
    seq = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

    reset = 1'b1;
    mispredict = 1'b0;
    set_req(3'b111);
    set_ready(3'b111);
    bus.alu_req_data = mk(1, 2, 30);
    bus.b_req_data   = mk(3, 4, 31);
    bus.lsu_req_data = mk(5, 6, 32);
    bus.prf_rdata1 = 32'h100;
    bus.prf_rdata2 = 32'h200;
    bus.cdb_valid  = '0;
    bus.cdb_tag    = '0;
    bus.cdb_data   = '0;

    // Reset held two cycles with every RS requesting.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_grant", 64'(grant_v()), 64'h0);
      check("rst_fu_valid", 64'(valid_v()), 64'h0);
    end
    check("rst_alu_op1", 64'(bus.alu_fu_op1), 64'h0);
    check("rst_lsu_data", 64'(bus.lsu_fu_data), 64'h0);
    reset = 1'b0;

    // Round-robin rotation with all requesting and all FUs ready.
    for (int i = 0; i < 6; i++) begin
      #1;
      check("rr_grant", 64'(grant_v()), 64'(3'b001 << seq[i]));
      check("rr_raddr1", 64'(bus.prf_raddr1), 64'(2 * seq[i] + 1));
      check("rr_raddr2", 64'(bus.prf_raddr2), 64'(2 * seq[i] + 2));
      tick();
      check("rr_fu_valid", 64'(valid_v()), 64'(3'b001 << seq[i]));
    end
    check("rr_lsu_op1", 64'(bus.lsu_fu_op1), 64'h100);
    check("rr_lsu_op2", 64'(bus.lsu_fu_op2), 64'h200);

    set_req(3'b000);
    #1;
    check("idle_raddr1", 64'(bus.prf_raddr1), 64'h0);
    tick();
    check("drain_fu_valid", 64'(valid_v()), 64'h0);

    // CDB bypass on pr1 for a BR issue.
    set_req(3'b010);
    bus.b_req_data = mk(12, 5, 33);
    bus.cdb_valid  = 3'b010;
    bus.cdb_tag[1] = 7'd12;
    bus.cdb_data[1] = 32'hDEAD_BEEF;
    bus.prf_rdata1 = 32'h1;
    bus.prf_rdata2 = 32'h55;
    #1;
    check("br_grant", 64'(grant_v()), 64'h2);
    check("br_raddr1", 64'(bus.prf_raddr1), 64'd12);
    check("br_raddr2", 64'(bus.prf_raddr2), 64'd5);
    tick();
    check("br_fu_valid", 64'(valid_v()), 64'h2);
    check("br_op1", 64'(bus.b_fu_op1), 64'hDEAD_BEEF);
    check("br_op2", 64'(bus.b_fu_op2), 64'h55);

    // Two valid CDB matches: slot 1 beats slot 2; invalid slot 0 ignored.
    set_req(3'b001);
    bus.alu_req_data = mk(12, 7, 34);
    bus.cdb_valid = 3'b110;
    bus.cdb_tag[0] = 7'd7;  bus.cdb_data[0] = 32'h1111;
    bus.cdb_tag[1] = 7'd12; bus.cdb_data[1] = 32'hAAAA;
    bus.cdb_tag[2] = 7'd12; bus.cdb_data[2] = 32'hBBBB;
    #1;
    check("alu_grant", 64'(grant_v()), 64'h1);
    tick();
    check("alu_fu_valid", 64'(valid_v()), 64'h1);
    check("cdb_lowest", 64'(bus.alu_fu_op1), 64'hAAAA);
    check("cdb_invalid", 64'(bus.alu_fu_op2), 64'h55);

    // Park rr_ptr on ALU while the ALU slot stays full.
    bus.cdb_valid = '0;
    set_ready(3'b110);
    set_req(3'b100);
    #1;
    check("park_grant", 64'(grant_v()), 64'h4);
    tick();
    check("park_fu_valid", 64'(valid_v()), 64'h5);

    // Blocked ALU slot: LSU wins even though ALU has priority.
    set_req(3'b101);
    bus.alu_req_data = mk(20, 21, 35);
    #1;
    check("blk_grant", 64'(grant_v()), 64'h4);
    tick();
    check("blk_fu_valid", 64'(valid_v()), 64'h5);
    check("blk_alu_hold", 64'(bus.alu_fu_op1), 64'hAAAA);

    // ALU drains and is reloaded in the same cycle.
    set_ready(3'b111);
    #1;
    check("drain_grant", 64'(grant_v()), 64'h1);
    tick();
    check("reload_fu_valid", 64'(valid_v()), 64'h1);
    check("reload_pr1", 64'(bus.alu_fu_data.pr1), 64'd20);
    check("reload_op1", 64'(bus.alu_fu_op1), 64'h1);

    // Fill LSU so ALU and LSU are both full with rr_ptr on ALU.
    set_ready(3'b110);
    set_req(3'b100);
    tick();
    check("fill_fu_valid", 64'(valid_v()), 64'h5);

    // Mispredict suppresses grants and flushes slots, pointer unchanged.
    mispredict = 1'b1;
    set_req(3'b111);
    set_ready(3'b000);
    #1;
    check("mp_grant", 64'(grant_v()), 64'h0);
    tick();
    check("mp_fu_valid", 64'(valid_v()), 64'h0);
    mispredict = 1'b0;
    set_ready(3'b111);
    #1;
    check("mp_ptr_hold", 64'(grant_v()), 64'h1);
    tick();

    // Register 0 sources read as zero despite PRF and CDB.
    set_req(3'b100);
    bus.lsu_req_data = mk(0, 0, 36);
    bus.prf_rdata1 = 32'hFFFF_FFFF;
    bus.prf_rdata2 = 32'hFFFF_FFFF;
    bus.cdb_valid = 3'b001;
    bus.cdb_tag[0] = 7'd0;
    bus.cdb_data[0] = 32'h1234;
    #1;
    check("r0_grant", 64'(grant_v()), 64'h4);
    tick();
    check("r0_fu_valid", 64'(valid_v()), 64'h4);
    check("r0_op1", 64'(bus.lsu_fu_op1), 64'h0);
    check("r0_op2", 64'(bus.lsu_fu_op2), 64'h0);

    // No requests: no grant, zero addresses, blocked LSU slot holds.
    set_req(3'b000);
    set_ready(3'b011);
    bus.cdb_valid = '0;
    #1;
    check("none_grant", 64'(grant_v()), 64'h0);
    check("none_raddr2", 64'(bus.prf_raddr2), 64'h0);
    tick();
    check("none_fu_valid", 64'(valid_v()), 64'h4);

    // Move rr_ptr to BR, then reset mid-operation returns it to ALU.
    set_req(3'b001);
    set_ready(3'b111);
    tick();
    reset = 1'b1;
    set_req(3'b111);
    tick();
    check("mrst_fu_valid", 64'(valid_v()), 64'h0);
    reset = 1'b0;
    #1;
    check("mrst_ptr", 64'(grant_v()), 64'h1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
